execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
EX stage of the 5-stage RV32I pipeline.
- Resolves operand forwarding from MEM/WB.
- Selects ALU sources (rs1/PC, rs2/imm).
- Derives the ALU operation from the ALUOp class plus funct3/funct7.
- Registers the ALU result and write-data value for the EX/MEM boundary.

Parameters:
- DATA_WIDTH, 32 (from shared package), datapath width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- EX_rd_data1_i  in  DATA_WIDTH  rs1 value from ID/EX
- EX_rd_data2_i  in  DATA_WIDTH  rs2 value from ID/EX
- MEM_alu_result_i  in  DATA_WIDTH  forwarding source, MEM stage
- WB_alu_result_i  in  DATA_WIDTH  forwarding source, WB stage write-back data
- EX_imm_i  in  DATA_WIDTH  sign/shift-extended immediate
- EX_pc_i  in  DATA_WIDTH  PC of the instruction
- EX_instruction_i  in  32  raw instruction (funct3 = [14:12], funct7 = [31:25])
- EX_ALUOpSrc1_i  in  1  0 = forwarded rs1, 1 = PC
- EX_ALUOpSrc2_i  in  1  0 = forwarded rs2, 1 = imm
- EX_ALUOp_i  in  alu_op_e  instruction class
- EX_forwardA_i  in  fw_sel_e  forwarding select, operand A
- EX_forwardB_i  in  fw_sel_e  forwarding select, operand B
- EX_alu_result_o  out  DATA_WIDTH  registered ALU result
- EX_wr_data_o  out  DATA_WIDTH  registered ALU operand B (post src2 mux)

Behaviour:
Forwarding mux (fwdX is the A or B mux output):
- FW_NONE → EX_rd_dataX_i
- FW_MEM_ALU → MEM_alu_result_i
- FW_WB_DATA → WB_alu_result_i
- any other encoding → EX_rd_dataX_i

Source muxes:
- opA = Src1 ? EX_pc_i : fwdA
- opB = Src2 ? EX_imm_i : fwdB

ALU control, by EX_ALUOp_i:
- ALUOP_RTYPE, by funct3: 000 ADD, or SUB if funct7 = 0100000; 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7[5]; 110 OR; 111 AND.
- ALUOP_ITYPE_ARITH: same funct3 map, except 000 is always ADD; 101 selects SRA if instr[30], else SRL.
- ALUOP_MEM_ADDR: ADD.
- ALUOP_JUMP: ADD.
- ALUOP_BRANCH: SUB.
- ALUOP_LUI: PASS_B.
- ALUOP_NONE and undefined encodings: result 0.

Arithmetic rules:
- Shift amount is opB[4:0].
- ADD/SUB wrap modulo 2^32; no flags are produced.
- SLT/SLTU return 32'd1 or 32'd0.

Output register:
- Combinational result and opB are captured on posedge clk into EX_alu_result_o and EX_wr_data_o.
- Latency is 1 cycle: inputs applied after edge N are visible after edge N+1.
- rst asserted → both outputs 0 immediately (async) and held at 0 while rst is high.
- Reset mid-operation discards the in-flight value; the first capture occurs on the first posedge after rst deasserts.
- Inputs are sampled every cycle; there is no stall or enable.

Decomposition:
Shared package defines:
- DATA_WIDTH = 32
- alu_op_e: ALUOP_NONE, ALUOP_RTYPE, ALUOP_ITYPE_ARITH, ALUOP_MEM_ADDR, ALUOP_BRANCH, ALUOP_LUI, ALUOP_JUMP (3 bits)
- fw_sel_e: FW_NONE = 0, FW_MEM_ALU = 1, FW_WB_DATA = 2 (2 bits)
- alu_ctrl_e: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B, ZERO
- FUNCT7_ADD = 7'b0000000, FUNCT7_SUB = 7'b0100000
- RV32I opcode constants

Structure:
- One sub-module, alu: opA, opB and alu_ctrl_e in, combinational result out.
- Forwarding, source muxing, ALU control decode and the output register live in execute_stage.

Test Plan:
- R-type ADD: rs1 = 10, rs2 = 5, funct3/funct7 = 0, src = 0/0, FW_NONE/FW_NONE → result 15, wr_data 5, one cycle later.
- ADDI and address calc: rs1 = 20, imm = 10, ALUOP_ITYPE_ARITH, src2 = 1 → 30 / 10. rs1 = 100, imm = 4, ALUOP_MEM_ADDR → 104 / 4.
- BRANCH, LUI, JALR, AUIPC:
  - rs1 = rs2 = 50, ALUOP_BRANCH → 0 / 50.
  - imm = 0xABCD0000, ALUOP_LUI, src2 = 1 → 0xABCD0000 / 0xABCD0000.
  - rs1 = 0x1000, imm = 8, ALUOP_JUMP → 0x1008 / 8.
  - pc = 0x2000, imm = 0x1000, src = 1/1, ALUOP_JUMP → 0x3000 / 0x1000.
- Forwarding, R-type ADD with rs1 = 10, rs2 = 5:
  - FW_MEM_ALU on A, MEM = 99 → 104 / 5.
  - FW_WB_DATA on B, WB = 88 → 98 / 88.
  - A = WB 66, B = MEM 77 → 143 / 77.
- ALU ops:
  - funct7 = 0100000 SUB: 5 − 10 → 0xFFFFFFFB.
  - SRA: 0x80000000 >>> 4 → 0xF8000000.
  - SLT: −1 < 1 → 1; SLTU on the same operands → 0.
  - ALUOP_NONE → result 0.
- Reset: assert rst asynchronously mid-cycle with nonzero outputs → both outputs 0 before the next edge. Deassert → the first edge loads the current result.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared types and constants for the RV32I execute stage.
// Holds ALU/forwarding enums, funct7 and opcode constants, and small decode helpers.
package execute_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int SHAMT_W    = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        ALUOP_NONE        = 3'd0,
        ALUOP_RTYPE       = 3'd1,
        ALUOP_ITYPE_ARITH = 3'd2,
        ALUOP_MEM_ADDR    = 3'd3,
        ALUOP_BRANCH      = 3'd4,
        ALUOP_LUI         = 3'd5,
        ALUOP_JUMP        = 3'd6
    } alu_op_e;

    typedef enum logic [1:0] {
        FW_NONE    = 2'd0,
        FW_MEM_ALU = 2'd1,
        FW_WB_DATA = 2'd2
    } fw_sel_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10,
        ALU_ZERO   = 4'd11
    } alu_ctrl_e;

    localparam logic [6:0] FUNCT7_ADD = 7'b0000000;
    localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Unknown select encodings fall back to the register-file value.
    function automatic logic [DATA_WIDTH-1:0] fwd_select(
        input fw_sel_e               sel,
        input logic [DATA_WIDTH-1:0] rd_data,
        input logic [DATA_WIDTH-1:0] mem_data,
        input logic [DATA_WIDTH-1:0] wb_data
    );
        logic [DATA_WIDTH-1:0] val;
        case (sel)
            FW_MEM_ALU: val = mem_data;
            FW_WB_DATA: val = wb_data;
            default:    val = rd_data;
        endcase
        return val;
    endfunction

    // Shared funct3 map for register and immediate arithmetic.
    function automatic alu_ctrl_e decode_funct3(
        input logic [2:0] funct3,
        input logic       use_sub,
        input logic       arith_shift
    );
        alu_ctrl_e ctrl;
        case (funct3)
            3'b000:  ctrl = use_sub ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl = ALU_SLL;
            3'b010:  ctrl = ALU_SLT;
            3'b011:  ctrl = ALU_SLTU;
            3'b100:  ctrl = ALU_XOR;
            3'b101:  ctrl = arith_shift ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl = ALU_OR;
            default: ctrl = ALU_AND;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX operand bundle into the execute stage and its registered EX/MEM results.
// master drives operands and controls; slave is the execute stage itself.
interface execute_stage_if;
    import execute_stage_pkg::*;

    logic [DATA_WIDTH-1:0] EX_rd_data1_i;
    logic [DATA_WIDTH-1:0] EX_rd_data2_i;
    logic [DATA_WIDTH-1:0] MEM_alu_result_i;
    logic [DATA_WIDTH-1:0] WB_alu_result_i;
    logic [DATA_WIDTH-1:0] EX_imm_i;
    logic [DATA_WIDTH-1:0] EX_pc_i;
    logic [31:0]           EX_instruction_i;
    logic                  EX_ALUOpSrc1_i;
    logic                  EX_ALUOpSrc2_i;
    alu_op_e               EX_ALUOp_i;
    fw_sel_e               EX_forwardA_i;
    fw_sel_e               EX_forwardB_i;
    logic [DATA_WIDTH-1:0] EX_alu_result_o;
    logic [DATA_WIDTH-1:0] EX_wr_data_o;

    modport master (
        output EX_rd_data1_i, EX_rd_data2_i, MEM_alu_result_i, WB_alu_result_i,
        output EX_imm_i, EX_pc_i, EX_instruction_i,
        output EX_ALUOpSrc1_i, EX_ALUOpSrc2_i, EX_ALUOp_i,
        output EX_forwardA_i, EX_forwardB_i,
        input  EX_alu_result_o, EX_wr_data_o
    );

    modport slave (
        input  EX_rd_data1_i, EX_rd_data2_i, MEM_alu_result_i, WB_alu_result_i,
        input  EX_imm_i, EX_pc_i, EX_instruction_i,
        input  EX_ALUOpSrc1_i, EX_ALUOpSrc2_i, EX_ALUOp_i,
        input  EX_forwardA_i, EX_forwardB_i,
        output EX_alu_result_o, EX_wr_data_o
    );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU: arithmetic, logic, shifts, compares, pass-B and zero.
// Latency 0 (pure combinational); no flow control.
module execute_stage_alu
    import execute_stage_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  alu_ctrl_e             ctrl,
    output logic [DATA_WIDTH-1:0] result
);

    logic [SHAMT_W-1:0] shamt;
    logic               lt_signed;
    logic               lt_unsigned;

    assign shamt       = op_b[SHAMT_W-1:0];
    assign lt_signed   = $signed(op_a) < $signed(op_b);
    assign lt_unsigned = op_a < op_b;

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:    result = op_a + op_b;
            ALU_SUB:    result = op_a - op_b;
            ALU_SLL:    result = op_a << shamt;
            ALU_SLT:    result = {{(DATA_WIDTH-1){1'b0}}, lt_signed};
            ALU_SLTU:   result = {{(DATA_WIDTH-1){1'b0}}, lt_unsigned};
            ALU_XOR:    result = op_a ^ op_b;
            ALU_SRL:    result = op_a >> shamt;
            ALU_SRA:    result = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:     result = op_a | op_b;
            ALU_AND:    result = op_a & op_b;
            ALU_PASS_B: result = op_b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// RV32I EX stage: forwarding, source muxes, ALU control decode, EX/MEM output register.
// Latency 1 cycle; no backpressure or stall, inputs are sampled on every clock.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);

    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    alu_ctrl_e             alu_ctrl;
    logic                  unused_instr_bits;

    assign funct3            = bus.EX_instruction_i[14:12];
    assign funct7            = bus.EX_instruction_i[31:25];
    assign unused_instr_bits = ^{bus.EX_instruction_i[24:15], bus.EX_instruction_i[11:0]};

    assign fwd_a = fwd_select(bus.EX_forwardA_i, bus.EX_rd_data1_i,
                              bus.MEM_alu_result_i, bus.WB_alu_result_i);
    assign fwd_b = fwd_select(bus.EX_forwardB_i, bus.EX_rd_data2_i,
                              bus.MEM_alu_result_i, bus.WB_alu_result_i);

    assign op_a = bus.EX_ALUOpSrc1_i ? bus.EX_pc_i  : fwd_a;
    assign op_b = bus.EX_ALUOpSrc2_i ? bus.EX_imm_i : fwd_b;

    // Immediate arithmetic never subtracts; bit 30 only picks SRAI over SRLI.
    always_comb begin
        alu_ctrl = ALU_ZERO;
        case (bus.EX_ALUOp_i)
            ALUOP_RTYPE:       alu_ctrl = decode_funct3(funct3, funct7 == FUNCT7_SUB, funct7[5]);
            ALUOP_ITYPE_ARITH: alu_ctrl = decode_funct3(funct3, 1'b0, funct7[5]);
            ALUOP_MEM_ADDR:    alu_ctrl = ALU_ADD;
            ALUOP_JUMP:        alu_ctrl = ALU_ADD;
            ALUOP_BRANCH:      alu_ctrl = ALU_SUB;
            ALUOP_LUI:         alu_ctrl = ALU_PASS_B;
            default:           alu_ctrl = ALU_ZERO;
        endcase
    end

    execute_stage_alu u_alu (
        .op_a   (op_a),
        .op_b   (op_b),
        .ctrl   (alu_ctrl),
        .result (alu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= '0;
            wr_data_q <= '0;
        end else begin
            result_q  <= alu_result;
            wr_data_q <= op_b;
        end
    end

    assign bus.EX_alu_result_o = result_q;
    assign bus.EX_wr_data_o    = wr_data_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected results,
// a monitor pops and compares one cycle after each issued vector.
module tb_execute_stage;
    import execute_stage_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] wr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic stim_vld;
    int   n_cmp;
    int   n_bad;
    exp_t exp_q[$];

    execute_stage_if bus();

    execute_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(
        input string       name,
        input logic [31:0] rd1, rd2, mem, wb, imm, pc,
        input logic [6:0]  f7,
        input logic [2:0]  f3,
        input logic        s1, s2,
        input alu_op_e     op,
        input fw_sel_e     fa, fb,
        input logic [31:0] exp_res, exp_wr
    );
        exp_t e;
        @(negedge clk);
        bus.EX_rd_data1_i    = rd1;
        bus.EX_rd_data2_i    = rd2;
        bus.MEM_alu_result_i = mem;
        bus.WB_alu_result_i  = wb;
        bus.EX_imm_i         = imm;
        bus.EX_pc_i          = pc;
        bus.EX_instruction_i = {f7, 10'b0, f3, 5'b0, OPC_OP};
        bus.EX_ALUOpSrc1_i   = s1;
        bus.EX_ALUOpSrc2_i   = s2;
        bus.EX_ALUOp_i       = op;
        bus.EX_forwardA_i    = fa;
        bus.EX_forwardB_i    = fb;
        e.name = name;
        e.res  = exp_res;
        e.wr   = exp_wr;
        exp_q.push_back(e);
        stim_vld = 1'b1;
    endtask

    // Monitor: a vector held across a posedge (out of reset) is visible just after it.
    initial begin
        logic v;
        logic r;
        exp_t e;
        forever begin
            @(posedge clk);
            v = stim_vld;
            r = rst;
            #2;
            if (v && !r) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard: output seen with empty queue, got 0x%08h", bus.EX_alu_result_o);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, " result"}, bus.EX_alu_result_o, e.res);
                    check({e.name, " wr_data"}, bus.EX_wr_data_o, e.wr);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        stim_vld = 1'b0;
        rst      = 1'b1;
        bus.EX_rd_data1_i    = '0;
        bus.EX_rd_data2_i    = '0;
        bus.MEM_alu_result_i = '0;
        bus.WB_alu_result_i  = '0;
        bus.EX_imm_i         = '0;
        bus.EX_pc_i          = '0;
        bus.EX_instruction_i = '0;
        bus.EX_ALUOpSrc1_i   = 1'b0;
        bus.EX_ALUOpSrc2_i   = 1'b0;
        bus.EX_ALUOp_i       = ALUOP_NONE;
        bus.EX_forwardA_i    = FW_NONE;
        bus.EX_forwardB_i    = FW_NONE;

        repeat (2) @(posedge clk);
        #2;
        check("reset result", bus.EX_alu_result_o, 32'h0);
        check("reset wr_data", bus.EX_wr_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //    name          rd1           rd2           mem       wb        imm           pc          f7           f3     s1    s2    op                 fa          fb          result        wr_data
        drive("add",        32'd10,       32'd5,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'd15,       32'd5);
        drive("addi",       32'd20,       32'd7,        32'd0,    32'd0,    32'd10,       32'd0,      7'b0100000, 3'b000, 1'b0, 1'b1, ALUOP_ITYPE_ARITH, FW_NONE,    FW_NONE,    32'd30,       32'd10);
        drive("mem_addr",   32'd100,      32'd9,        32'd0,    32'd0,    32'd4,        32'd0,      7'b0000000, 3'b010, 1'b0, 1'b1, ALUOP_MEM_ADDR,    FW_NONE,    FW_NONE,    32'd104,      32'd4);
        drive("branch",     32'd50,       32'd50,       32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, ALUOP_BRANCH,      FW_NONE,    FW_NONE,    32'd0,        32'd50);
        drive("lui",        32'h1234,     32'd3,        32'd0,    32'd0,    32'hABCD0000, 32'd0,      7'b0000000, 3'b000, 1'b0, 1'b1, ALUOP_LUI,         FW_NONE,    FW_NONE,    32'hABCD0000, 32'hABCD0000);
        drive("jalr",       32'h1000,     32'd0,        32'd0,    32'd0,    32'd8,        32'h40,     7'b0000000, 3'b000, 1'b0, 1'b1, ALUOP_JUMP,        FW_NONE,    FW_NONE,    32'h1008,     32'd8);
        drive("auipc",      32'h5555,     32'd0,        32'd0,    32'd0,    32'h1000,     32'h2000,   7'b0000000, 3'b000, 1'b1, 1'b1, ALUOP_JUMP,        FW_NONE,    FW_NONE,    32'h3000,     32'h1000);
        drive("fwd_a_mem",  32'd10,       32'd5,        32'd99,   32'd0,    32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, ALUOP_RTYPE,       FW_MEM_ALU, FW_NONE,    32'd104,      32'd5);
        drive("fwd_b_wb",   32'd10,       32'd5,        32'd99,   32'd88,   32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_WB_DATA, 32'd98,       32'd88);
        drive("fwd_both",   32'd10,       32'd5,        32'd77,   32'd66,   32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, ALUOP_RTYPE,       FW_WB_DATA, FW_MEM_ALU, 32'd143,      32'd77);
        drive("fwd_undef",  32'd10,       32'd5,        32'd77,   32'd66,   32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, ALUOP_RTYPE,       fw_sel_e'(2'd3), fw_sel_e'(2'd3), 32'd15, 32'd5);
        drive("sub",        32'd5,        32'd10,       32'd0,    32'd0,    32'd0,        32'd0,      7'b0100000, 3'b000, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'hFFFFFFFB, 32'd10);
        drive("add_f7_odd", 32'd10,       32'd5,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0100001, 3'b000, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'd15,       32'd5);
        drive("sra",        32'h80000000, 32'd4,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0100000, 3'b101, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'hF8000000, 32'd4);
        drive("srl",        32'h80000000, 32'd4,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b101, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'h08000000, 32'd4);
        drive("srai",       32'h80000000, 32'd0,        32'd0,    32'd0,    32'h404,      32'd0,      7'b0100000, 3'b101, 1'b0, 1'b1, ALUOP_ITYPE_ARITH, FW_NONE,    FW_NONE,    32'hF8000000, 32'h404);
        drive("sll_shamt",  32'd1,        32'h21,       32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b001, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'd2,        32'h21);
        drive("slt",        32'hFFFFFFFF, 32'd1,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b010, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'd1,        32'd1);
        drive("sltu",       32'hFFFFFFFF, 32'd1,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b011, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'd0,        32'd1);
        drive("xor",        32'hF0F0,     32'hFF00,     32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b100, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'h0FF0,     32'hFF00);
        drive("or",         32'hF0F0,     32'hFF00,     32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b110, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'hFFF0,     32'hFF00);
        drive("and",        32'hF0F0,     32'hFF00,     32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b111, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'hF000,     32'hFF00);
        drive("aluop_none", 32'd10,       32'd5,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, ALUOP_NONE,        FW_NONE,    FW_NONE,    32'd0,        32'd5);
        drive("aluop_undef",32'd10,       32'd5,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, alu_op_e'(3'd7),   FW_NONE,    FW_NONE,    32'd0,        32'd5);

        // Asynchronous reset mid-cycle while outputs hold a nonzero value.
        drive("pre_reset",  32'd10,       32'd5,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'd15,       32'd5);
        @(posedge clk);
        #4;
        stim_vld = 1'b0;
        rst      = 1'b1;
        #1;
        check("async_rst result", bus.EX_alu_result_o, 32'h0);
        check("async_rst wr_data", bus.EX_wr_data_o, 32'h0);
        @(posedge clk);
        #2;
        check("rst_hold result", bus.EX_alu_result_o, 32'h0);
        check("rst_hold wr_data", bus.EX_wr_data_o, 32'h0);

        drive("post_reset", 32'd7,        32'd8,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'd15,       32'd8);
        #1;
        check("rst_before_release result", bus.EX_alu_result_o, 32'h0);
        #1;
        rst = 1'b0;
        drive("after_rel",  32'd3,        32'd4,        32'd0,    32'd0,    32'd0,        32'd0,      7'b0000000, 3'b000, 1'b0, 1'b0, ALUOP_RTYPE,       FW_NONE,    FW_NONE,    32'd7,        32'd4);

        @(negedge clk);
        stim_vld = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
